// File: rtl/alu_reservation_station_if.sv
// Dispatch, broadcast and completion signals between the reorder buffer and the ALU
// reservation station.
interface alu_rs_if #(
    parameter int unsigned size     = 8,
    parameter int unsigned rob_size = 8,
    parameter int unsigned width    = 32
);
    typedef struct packed {
        logic [3:0]       tag;
        logic             rdy;
        logic [width-1:0] data;
    } sal_t;

    logic             load;
    logic [3:0]       rd_tag;
    logic [2:0]       alu_op;
    logic             src1_rdy;
    logic             src2_rdy;
    logic [width-1:0] src1_val;
    logic [width-1:0] src2_val;
    logic [3:0]       src1_tag;
    logic [3:0]       src2_tag;
    sal_t             rob_broadcast_bus [rob_size];
    logic             stall;
    sal_t             alu_rs_o [size];

    modport master (
        output load, rd_tag, alu_op, src1_rdy, src2_rdy, src1_val, src2_val,
        output src1_tag, src2_tag, rob_broadcast_bus,
        input  stall, alu_rs_o
    );

    modport slave (
        input  load, rd_tag, alu_op, src1_rdy, src2_rdy, src1_val, src2_val,
        input  src1_tag, src2_tag, rob_broadcast_bus,
        output stall, alu_rs_o
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops, snoops the ROB broadcast bus for missing
// operands and executes every entry whose operands are both ready, all in parallel.
module alu_reservation_station #(
    parameter int unsigned size     = 8,
    parameter int unsigned rob_size = 8,
    parameter int unsigned width    = 32
) (
    input logic clk,
    input logic rst,
    alu_rs_if.slave rs
);
    localparam int unsigned BusIdxW = (rob_size > 1) ? $clog2(rob_size) : 1;

    logic [size-1:0]    busy_q;
    logic [2:0]         op_q   [size];
    logic [3:0]         tag_q  [size];
    logic [width-1:0]   vj_q   [size];
    logic [width-1:0]   vk_q   [size];
    logic [BusIdxW-1:0] qj_q   [size];
    logic [BusIdxW-1:0] qk_q   [size];
    logic [size-1:0]    rj_q;
    logic [size-1:0]    rk_q;

    logic [size-1:0]    done_q;
    logic [3:0]         done_tag_q  [size];
    logic [width-1:0]   done_data_q [size];

    logic [size-1:0]    alloc_sel;
    logic [size-1:0]    exec;
    logic [width-1:0]   result [size];
    logic [size-1:0]    j_hit;
    logic [size-1:0]    k_hit;
    logic [width-1:0]   j_data [size];
    logic [width-1:0]   k_data [size];
    logic               load_ok;
    logic               free_found;
    logic [BusIdxW-1:0] s1_idx;
    logic [BusIdxW-1:0] s2_idx;
    logic               unused_inputs;

    function automatic logic [width-1:0] alu(input logic [2:0] op,
                                             input logic [width-1:0] a,
                                             input logic [width-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return $signed(a) >>> b[4:0];
            3'd3:    return a - b;
            3'd4:    return a ^ b;
            3'd5:    return a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    assign s1_idx   = rs.src1_tag[BusIdxW-1:0];
    assign s2_idx   = rs.src2_tag[BusIdxW-1:0];
    assign rs.stall = &busy_q;

    always_comb begin
        load_ok       = rs.load && !(&busy_q);
        free_found    = 1'b0;
        unused_inputs = ^{rs.src1_tag, rs.src2_tag};
        for (int t = 0; t < rob_size; t++) begin
            unused_inputs = unused_inputs ^ (^rs.rob_broadcast_bus[t].tag);
        end
        for (int i = 0; i < size; i++) begin
            alloc_sel[i] = 1'b0;
            exec[i]      = busy_q[i] && rj_q[i] && rk_q[i];
            result[i]    = alu(op_q[i], vj_q[i], vk_q[i]);
            j_hit[i]     = rs.rob_broadcast_bus[qj_q[i]].rdy;
            j_data[i]    = rs.rob_broadcast_bus[qj_q[i]].data;
            k_hit[i]     = rs.rob_broadcast_bus[qk_q[i]].rdy;
            k_data[i]    = rs.rob_broadcast_bus[qk_q[i]].data;
            // Lowest-index free entry takes the dispatch.
            if (!busy_q[i] && !free_found) begin
                alloc_sel[i] = load_ok;
                free_found   = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < size; i++) begin
            rs.alu_rs_o[i].tag  = done_tag_q[i];
            rs.alu_rs_o[i].rdy  = done_q[i];
            rs.alu_rs_o[i].data = done_data_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            done_q <= '0;
            for (int i = 0; i < size; i++) begin
                done_tag_q[i]  <= '0;
                done_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < size; i++) begin
                // Completion port is a one-cycle pulse; idle cycles drive all zeros.
                done_q[i]      <= exec[i];
                done_tag_q[i]  <= exec[i] ? tag_q[i] : 4'd0;
                done_data_q[i] <= exec[i] ? result[i] : '0;
                if (exec[i]) begin
                    busy_q[i] <= 1'b0;
                end else if (alloc_sel[i]) begin
                    busy_q[i] <= 1'b1;
                    op_q[i]   <= rs.alu_op;
                    tag_q[i]  <= rs.rd_tag;
                    qj_q[i]   <= s1_idx;
                    qk_q[i]   <= s2_idx;
                    rj_q[i]   <= rs.src1_rdy || rs.rob_broadcast_bus[s1_idx].rdy;
                    rk_q[i]   <= rs.src2_rdy || rs.rob_broadcast_bus[s2_idx].rdy;
                    vj_q[i]   <= rs.src1_rdy ? rs.src1_val : rs.rob_broadcast_bus[s1_idx].data;
                    vk_q[i]   <= rs.src2_rdy ? rs.src2_val : rs.rob_broadcast_bus[s2_idx].data;
                end else if (busy_q[i]) begin
                    if (!rj_q[i] && j_hit[i]) begin
                        rj_q[i] <= 1'b1;
                        vj_q[i] <= j_data[i];
                    end
                    if (!rk_q[i] && k_hit[i]) begin
                        rk_q[i] <= 1'b1;
                        vk_q[i] <= k_data[i];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios plus a randomized run checked
// against an instruction-level model of when each dispatched op retires.
module tb_alu_reservation_station;
    localparam int unsigned Size    = 8;
    localparam int unsigned RobSize = 8;
    localparam int unsigned Width   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_rs_if #(.size(Size), .rob_size(RobSize), .width(Width)) rs_if ();

    alu_reservation_station #(.size(Size), .rob_size(RobSize), .width(Width)) dut (
        .clk (clk),
        .rst (rst),
        .rs  (rs_if)
    );

    // Model: an op retires on the edge after every operand is known; an operand becomes
    // known at the first edge (dispatch edge included) where its producer is on the bus.
    typedef struct {
        bit          busy;
        logic [3:0]  tag;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          a_ok;
        bit          b_ok;
        logic [2:0]  qa;
        logic [2:0]  qb;
    } instr_t;

    instr_t      m [Size];
    logic [36:0] m_out [Size];
    bit          m_stall;

    function automatic logic [36:0] out_of(input int i);
        return rs_if.alu_rs_o[i];
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int          s;
        logic [31:0] fill;
        s    = int'(b[4:0]);
        fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a << s;
            3'd2:    return (a >> s) | fill;
            3'd3:    return a - b;
            3'd4:    return a ^ b;
            3'd5:    return a >> s;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bus();
        for (int t = 0; t < RobSize; t++) begin
            rs_if.rob_broadcast_bus[t].tag  = 4'(t);
            rs_if.rob_broadcast_bus[t].rdy  = 1'b0;
            rs_if.rob_broadcast_bus[t].data = 32'd0;
        end
    endtask

    task automatic set_bus(input int t, input logic [31:0] d);
        rs_if.rob_broadcast_bus[t].tag  = 4'(t);
        rs_if.rob_broadcast_bus[t].rdy  = 1'b1;
        rs_if.rob_broadcast_bus[t].data = d;
    endtask

    task automatic drive_load(input logic [2:0] op, input logic [3:0] tag,
                              input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                              input logic r2, input logic [31:0] v2, input logic [3:0] t2);
        rs_if.load     = 1'b1;
        rs_if.alu_op   = op;
        rs_if.rd_tag   = tag;
        rs_if.src1_rdy = r1;
        rs_if.src1_val = v1;
        rs_if.src1_tag = t1;
        rs_if.src2_rdy = r2;
        rs_if.src2_val = v2;
        rs_if.src2_tag = t2;
    endtask

    task automatic model_reset();
        for (int i = 0; i < Size; i++) begin
            m[i].busy = 1'b0;
            m_out[i]  = 37'd0;
        end
        m_stall = 1'b0;
    endtask

    task automatic model_edge();
        int slot;
        slot = -1;
        if (rs_if.load) begin
            for (int i = Size - 1; i >= 0; i--) if (!m[i].busy) slot = i;
        end
        for (int i = 0; i < Size; i++) begin
            m_out[i] = 37'd0;
            if (m[i].busy) begin
                if (m[i].a_ok && m[i].b_ok) begin
                    m_out[i]  = {m[i].tag, 1'b1, ref_alu(m[i].op, m[i].a, m[i].b)};
                    m[i].busy = 1'b0;
                end else begin
                    if (!m[i].a_ok && rs_if.rob_broadcast_bus[m[i].qa].rdy) begin
                        m[i].a_ok = 1'b1;
                        m[i].a    = rs_if.rob_broadcast_bus[m[i].qa].data;
                    end
                    if (!m[i].b_ok && rs_if.rob_broadcast_bus[m[i].qb].rdy) begin
                        m[i].b_ok = 1'b1;
                        m[i].b    = rs_if.rob_broadcast_bus[m[i].qb].data;
                    end
                end
            end
        end
        if (slot >= 0) begin
            m[slot].busy = 1'b1;
            m[slot].tag  = rs_if.rd_tag;
            m[slot].op   = rs_if.alu_op;
            m[slot].qa   = rs_if.src1_tag[2:0];
            m[slot].qb   = rs_if.src2_tag[2:0];
            m[slot].a_ok = rs_if.src1_rdy || rs_if.rob_broadcast_bus[m[slot].qa].rdy;
            m[slot].b_ok = rs_if.src2_rdy || rs_if.rob_broadcast_bus[m[slot].qb].rdy;
            m[slot].a    = rs_if.src1_rdy ? rs_if.src1_val
                                          : rs_if.rob_broadcast_bus[m[slot].qa].data;
            m[slot].b    = rs_if.src2_rdy ? rs_if.src2_val
                                          : rs_if.rob_broadcast_bus[m[slot].qb].data;
        end
        m_stall = 1'b1;
        for (int i = 0; i < Size; i++) if (!m[i].busy) m_stall = 1'b0;
    endtask

    task automatic test_reset();
        clear_bus();
        drive_load(3'd0, 4'd9, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        rs_if.load = 1'b0;
        n_cmp++;
        if (rs_if.stall !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stall: got %b want 0", rs_if.stall);
        end
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < Size; i++) begin
                n_cmp++;
                if (out_of(i) !== 37'd0) begin
                    n_bad++;
                    $display("FAIL reset_out[%0d] cyc %0d: got %h want 0", i, c, out_of(i));
                end
            end
            step();
        end
    endtask

    task automatic test_ready_dispatch();
        drive_load(3'd0, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
        step();
        rs_if.load = 1'b0;
        n_cmp++;
        if (rs_if.stall !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_stall: got %b want 0", rs_if.stall);
        end
        step();
        n_cmp++;
        if (out_of(0) !== {4'd3, 1'b1, 32'd12}) begin
            n_bad++;
            $display("FAIL ready_result: got %h want %h", out_of(0), {4'd3, 1'b1, 32'd12});
        end
        step();
        n_cmp++;
        if (out_of(0) !== 37'd0) begin
            n_bad++;
            $display("FAIL ready_pulse_clear: got %h want 0", out_of(0));
        end
    endtask

    task automatic test_wakeup();
        clear_bus();
        drive_load(3'd3, 4'd2, 1'b1, 32'd10, 4'd0, 1'b0, 32'd0, 4'd5);
        step();
        rs_if.load = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            n_cmp++;
            if (out_of(0) !== 37'd0) begin
                n_bad++;
                $display("FAIL wakeup_hold cyc %0d: got %h want 0", c, out_of(0));
            end
        end
        set_bus(5, 32'd3);
        step();
        n_cmp++;
        if (out_of(0) !== 37'd0) begin
            n_bad++;
            $display("FAIL wakeup_capture: got %h want 0", out_of(0));
        end
        step();
        n_cmp++;
        if (out_of(0) !== {4'd2, 1'b1, 32'd7}) begin
            n_bad++;
            $display("FAIL wakeup_result: got %h want %h", out_of(0), {4'd2, 1'b1, 32'd7});
        end
        clear_bus();
        step();
        n_cmp++;
        if (out_of(0) !== 37'd0) begin
            n_bad++;
            $display("FAIL wakeup_once: got %h want 0", out_of(0));
        end
    endtask

    task automatic test_bypass();
        set_bus(1, 32'hFFFF_FFF0);
        drive_load(3'd2, 4'd4, 1'b0, 32'd0, 4'd1, 1'b1, 32'd4, 4'd0);
        step();
        rs_if.load = 1'b0;
        clear_bus();
        step();
        n_cmp++;
        if (out_of(0) !== {4'd4, 1'b1, 32'hFFFF_FFFF}) begin
            n_bad++;
            $display("FAIL bypass_result: got %h want %h", out_of(0),
                     {4'd4, 1'b1, 32'hFFFF_FFFF});
        end
        step();
    endtask

    task automatic test_full();
        clear_bus();
        for (int k = 0; k < Size; k++) begin
            drive_load(3'd0, 4'(k), 1'b0, 32'd0, 4'd6, 1'b0, 32'd0, 4'd6);
            step();
        end
        rs_if.load = 1'b0;
        n_cmp++;
        if (rs_if.stall !== 1'b1) begin
            n_bad++;
            $display("FAIL full_stall: got %b want 1", rs_if.stall);
        end
        drive_load(3'd0, 4'd9, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
        step();
        rs_if.load = 1'b0;
        n_cmp++;
        if (rs_if.stall !== 1'b1) begin
            n_bad++;
            $display("FAIL full_ignored_stall: got %b want 1", rs_if.stall);
        end
        set_bus(6, 32'h1234_5678);
        step();
        for (int i = 0; i < Size; i++) begin
            n_cmp++;
            if (out_of(i) !== 37'd0) begin
                n_bad++;
                $display("FAIL full_early[%0d]: got %h want 0", i, out_of(i));
            end
        end
        step();
        for (int i = 0; i < Size; i++) begin
            n_cmp++;
            if (out_of(i) !== {4'(i), 1'b1, 32'h2468_ACF0}) begin
                n_bad++;
                $display("FAIL full_result[%0d]: got %h want %h", i, out_of(i),
                         {4'(i), 1'b1, 32'h2468_ACF0});
            end
        end
        n_cmp++;
        if (rs_if.stall !== 1'b0) begin
            n_bad++;
            $display("FAIL full_release_stall: got %b want 0", rs_if.stall);
        end
        clear_bus();
        step();
        for (int i = 0; i < Size; i++) begin
            n_cmp++;
            if (out_of(i) !== 37'd0) begin
                n_bad++;
                $display("FAIL full_after[%0d]: got %h want 0", i, out_of(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_bus();
        for (int k = 0; k < 3; k++) begin
            drive_load(3'd0, 4'(k + 10), 1'b0, 32'd0, 4'(k + 2), 1'b1, 32'd1, 4'd0);
            step();
        end
        rs_if.load = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) set_bus(k + 2, 32'(k + 100));
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if (rs_if.stall !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid_stall cyc %0d: got %b want 0", c, rs_if.stall);
            end
            for (int i = 0; i < Size; i++) begin
                n_cmp++;
                if (out_of(i) !== 37'd0) begin
                    n_bad++;
                    $display("FAIL rstmid_out[%0d] cyc %0d: got %h want 0", i, c, out_of(i));
                end
            end
        end
        clear_bus();
    endtask

    task automatic test_random();
        clear_bus();
        rs_if.load = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int t = 0; t < RobSize; t++) begin
                if (rs_if.rob_broadcast_bus[t].rdy) begin
                    if ($urandom_range(7) == 0) rs_if.rob_broadcast_bus[t].rdy = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    set_bus(t, $urandom);
                end
            end
            rs_if.load     = ($urandom_range(2) != 0);
            rs_if.alu_op   = 3'($urandom_range(7));
            rs_if.rd_tag   = 4'($urandom_range(15));
            rs_if.src1_rdy = 1'($urandom_range(1));
            rs_if.src2_rdy = 1'($urandom_range(1));
            rs_if.src1_val = $urandom;
            rs_if.src2_val = ($urandom_range(1) != 0) ? 32'($urandom_range(40)) : $urandom;
            rs_if.src1_tag = 4'($urandom_range(7));
            rs_if.src2_tag = 4'($urandom_range(7));
            model_edge();
            step();
            n_cmp++;
            if (rs_if.stall !== m_stall) begin
                n_bad++;
                $display("FAIL rand_stall cyc %0d: got %b want %b", cyc, rs_if.stall, m_stall);
            end
            for (int i = 0; i < Size; i++) begin
                n_cmp++;
                if (out_of(i) !== m_out[i]) begin
                    n_bad++;
                    $display("FAIL rand_out[%0d] cyc %0d: got %h want %h", i, cyc, out_of(i),
                             m_out[i]);
                end
            end
        end
        rs_if.load = 1'b0;
    endtask

    initial begin
        rs_if.load     = 1'b0;
        rs_if.alu_op   = 3'd0;
        rs_if.rd_tag   = 4'd0;
        rs_if.src1_rdy = 1'b0;
        rs_if.src2_rdy = 1'b0;
        rs_if.src1_val = 32'd0;
        rs_if.src2_val = 32'd0;
        rs_if.src1_tag = 4'd0;
        rs_if.src2_tag = 4'd0;
        clear_bus();
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_bypass();
        test_full();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Holds up to `size` dispatched ALU instructions and tracks the ROB tag of each not-ready source operand. It captures operand values from the ROB broadcast bus, then executes each entry once both operands are ready. Each result is returned on a per-entry `sal_t` completion port, which the reorder buffer scans. The block is the responder to the ROB dispatch/complete protocol: it consumes `load_alu_rs`, `rd_tag` and `rob_broadcast_bus`, and produces `alu_rs_o` and `stall_alu`.

## Interface
- `size`, 8: number of RS entries (equals the `alu_rs_o` array length).
- `rob_size`, 8: ROB depth; the length of the broadcast bus.
- `width`, 32: operand and result width.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `load` in 1: dispatch strobe (ROB `load_alu_rs`).
- `rd_tag` in 4: ROB tag of the instruction being dispatched.
- `alu_op` in 3: operation. 0 add, 1 sll, 2 sra, 3 sub, 4 xor, 5 srl, 6 or, 7 and.
- `src1_rdy`, `src2_rdy` in 1 each: operand value already valid.
- `src1_val`, `src2_val` in `width` each: operand value, meaningful when the matching `_rdy` is 1.
- `src1_tag`, `src2_tag` in 4 each: ROB tag producing the operand, meaningful when the matching `_rdy` is 0.
- `rob_broadcast_bus` in `sal_t`[`rob_size`]: `{tag, rdy, data}` per ROB slot; `rdy`=1 means `data` is final.
- `stall` out 1: all entries occupied (drives the ROB's `stall_alu`).
- `alu_rs_o` out `sal_t`[`size`]: per-entry completion `{tag, rdy, data}`.

## Operation
- Per-entry state:
  - `busy`
  - `op`
  - `tag`
  - for each of j and k: value, producer tag, ready bit
- **Allocate:** when `load`=1 and `stall`=0, the lowest-index non-busy entry is written at the clock edge.
  - `load` while `stall`=1 is ignored. No state changes and no error is raised; the ROB must not assert `load` in that case.
- **Dispatch bypass:** if a source is not ready at dispatch and `rob_broadcast_bus[src_tag].rdy`=1 in the same cycle, the entry captures `.data` and is stored as ready.
- **Wakeup:**
  - Each cycle, every busy entry with a not-ready operand q checks `rob_broadcast_bus[q]`.
  - If `rdy`=1, the operand value and ready bit are written at the edge.
  - The bus is level-held, so a missed cycle is not fatal.
- **Execute:** a busy entry with both operands ready computes combinationally in that cycle.
  - Shifts use `vk[4:0]`.
  - `sra` is arithmetic.
  - add and sub wrap modulo 2^32.
- **Complete:** at the edge ending the execute cycle, `alu_rs_o[i]` <= `{tag, 1, result}` and `busy[i]` <= 0.
- **Pulse clear:** `alu_rs_o[i].rdy` is high for exactly one cycle, then returns to `'{default:0}`.
- **Tags:** tag 0 is a legal ROB tag; producer-tag matches are qualified by the operand ready bit, never by tag!=0.
- `stall` = AND of all `busy`, as a registered-state function.
  - An entry freed at edge t is reusable by a `load` sampled at edge t+1, not at edge t.
- All entries execute in parallel; there is no issue arbitration and no limit on completions per cycle.

## Timing
- **Reset** (rst sampled 1):
  - all `busy`=0
  - all `alu_rs_o` = `'{default:0}`
  - `stall`=0
  - Reset overrides a simultaneous `load` and any in-flight wakeup or completion.
- **Latency:**
  - Both operands ready at dispatch: `load` sampled at edge t, result on `alu_rs_o` during cycle t+1..t+2 (written at edge t+1).
  - Waiting operand: broadcast seen in cycle c is captured at edge c, and the result is written at edge c+1 if the other operand is ready.
- **Load plus wakeup in the same cycle** is legal; both happen in the same edge on different entries.
- **Load into the last free entry:** `stall` rises the cycle after that edge.
- Completions and frees happen independently of `load`.

## Test plan
- **Reset check:** assert `rst` for 2 cycles with `load`=1 held. Then `stall`=0, every `alu_rs_o[i]`={0,0,0}, and no entry allocated.
- **Ready dispatch:** dispatch `add` with `rd_tag`=3, src1=5 and src2=7, both ready. One cycle after the load edge, `alu_rs_o[0]`={3,1,12}. The following cycle, `rdy`=0.
- **Wakeup:** dispatch `sub` with `rd_tag`=2, src1 ready=10, and src2 waiting on tag 5.
  - Hold with `rob_broadcast_bus[5].rdy`=0 for 4 cycles: no completion.
  - Set it to {5,1,3}: the result {2,1,7} appears 2 edges later.
- **Same-cycle bypass:** dispatch with src1 waiting on tag 1 while `rob_broadcast_bus[1]`={1,1,0xFFFF_FFF0}, op `sra`, src2=4. Completion is {tag,1,0xFFFF_FFFF} one cycle after the load edge.
- **Full boundary:**
  - Dispatch 8 instructions whose operands are all waiting on tag 6.
  - `stall`=1 after the 8th; a 9th `load` is ignored.
  - Broadcast tag 6: all 8 complete on the same edge, and `stall`=0 the next cycle.
- **Reset mid-operation:** with 3 entries waiting, assert `rst`. Then broadcast their tags: no `alu_rs_o` activity occurs.
